// File: rtl/gray_counter.sv
// rtl/gray_counter.sv - registered Gray-code up/down counter with one-deep valid/ready output
module gray_counter #(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gray_out,
  output logic             out_valid,
  output logic             busy,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0] bin_cnt;
  logic [WIDTH-1:0] step_val;
  logic             at_bound;
  logic             acc;

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  always_comb begin
    acc      = ~out_valid | out_ready;
    at_bound = dir ? (bin_cnt == MAX) : (bin_cnt == '0);
    step_val = bin_cnt;
    if (at_bound) begin
      // At a bound: hold in saturate mode, otherwise jump to the opposite bound.
      if (SATURATE) step_val = bin_cnt;
      else          step_val = dir ? '0 : MAX;
    end else begin
      step_val = dir ? bin_cnt + 1'b1 : bin_cnt - 1'b1;
    end
  end

  assign busy = out_valid & ~out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_cnt   <= '0;
      gray_out  <= '0;
      out_valid <= 1'b0;
      tc        <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (acc) begin
        if (load) begin
          bin_cnt   <= load_bin;
          gray_out  <= to_gray(load_bin);
          out_valid <= 1'b1;
        end else if (en) begin
          bin_cnt   <= step_val;
          gray_out  <= to_gray(step_val);
          out_valid <= 1'b1;
          tc        <= at_bound;
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
// tb/tb_gray_counter.sv - scoreboard bench for gray_counter in wrap and saturate modes
module tb_gray_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, dir, load, out_ready;
  logic [3:0] load_bin;
  logic [3:0] g0, g1;
  logic       v0, v1, b0, b1, t0, t1;

  int checks = 0;
  int errors = 0;

  typedef struct {logic [3:0] g; logic tc;} exp_t;
  exp_t q0[$];
  exp_t q1[$];

  int mbin[2];
  bit mvld[2];

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(4), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .load(load), .load_bin(load_bin),
    .out_ready(out_ready), .gray_out(g0), .out_valid(v0), .busy(b0), .tc(t0)
  );

  gray_counter #(.WIDTH(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .load(load), .load_bin(load_bin),
    .out_ready(out_ready), .gray_out(g1), .out_valid(v1), .busy(b1), .tc(t1)
  );

  function automatic logic [3:0] gray_of(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic int bin_of(input logic [3:0] g);
    int r;
    int bit_acc;
    r = 0;
    bit_acc = 0;
    for (int i = 3; i >= 0; i--) begin
      bit_acc = bit_acc ^ int'(g[i]);
      r = r + (bit_acc << i);
    end
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One request cycle: issue inputs, predict both instances, commit model after the edge.
  task automatic step(input bit e, input bit d, input bit l, input logic [3:0] lb, input bit r);
    int  nb[2];
    bit  nv[2];
    exp_t x;
    en = e; dir = d; load = l; load_bin = lb; out_ready = r;
    for (int i = 0; i < 2; i++) begin
      nb[i] = mbin[i];
      nv[i] = mvld[i];
      if (!mvld[i] || r) begin
        if (l) begin
          nb[i] = int'(lb);
          nv[i] = 1'b1;
          x.g = gray_of(nb[i]); x.tc = 1'b0;
          if (i == 0) q0.push_back(x); else q1.push_back(x);
        end else if (e) begin
          x.tc = 1'b0;
          nb[i] = d ? mbin[i] + 1 : mbin[i] - 1;
          if (nb[i] > 15 || nb[i] < 0) begin
            x.tc = 1'b1;
            if (i == 1) nb[i] = mbin[i];
            else        nb[i] = (nb[i] > 15) ? 0 : 15;
          end
          nv[i] = 1'b1;
          x.g = gray_of(nb[i]);
          if (i == 0) q0.push_back(x); else q1.push_back(x);
        end else if (r) begin
          nv[i] = 1'b0;
        end
      end
    end
    @(posedge clk);
    mbin = nb;
    mvld = nv;
    #1;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    en = 1'b0; load = 1'b0;
    #1;
    chk("rst_gray_wrap", int'(g0), 0);
    chk("rst_valid_wrap", int'(v0), 0);
    chk("rst_tc_wrap", int'(t0), 0);
    chk("rst_gray_sat", int'(g1), 0);
    chk("rst_valid_sat", int'(v1), 0);
    q0.delete();
    q1.delete();
    mbin[0] = 0; mbin[1] = 0;
    mvld[0] = 1'b0; mvld[1] = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: a code is new when valid rises or the previous one was consumed.
  bit pv0 = 1'b0, pv1 = 1'b0, pr = 1'b0;
  always @(negedge clk) begin
    exp_t x;
    if (!rst_n) begin
      pv0 = 1'b0; pv1 = 1'b0; pr = 1'b0;
    end else begin
      chk("valid_wrap", int'(v0), int'(mvld[0]));
      chk("valid_sat", int'(v1), int'(mvld[1]));
      chk("busy_wrap", int'(b0), int'(mvld[0] & ~out_ready));
      chk("busy_sat", int'(b1), int'(mvld[1] & ~out_ready));
      chk("decode_wrap", bin_of(g0), mbin[0]);
      chk("decode_sat", bin_of(g1), mbin[1]);
      if (v0 && (!pv0 || pr)) begin
        if (q0.size() == 0) chk("underflow_wrap", 1, 0);
        else begin
          x = q0.pop_front();
          chk("code_wrap", int'(g0), int'(x.g));
          chk("tc_wrap", int'(t0), int'(x.tc));
        end
      end else chk("tc_idle_wrap", int'(t0), 0);
      if (v1 && (!pv1 || pr)) begin
        if (q1.size() == 0) chk("underflow_sat", 1, 0);
        else begin
          x = q1.pop_front();
          chk("code_sat", int'(g1), int'(x.g));
          chk("tc_sat", int'(t1), int'(x.tc));
        end
      end else chk("tc_idle_sat", int'(t1), 0);
      pv0 = v0; pv1 = v1; pr = out_ready;
    end
  end

  initial begin
    logic [3:0] prev;
    rst_n = 1'b0; en = 1'b0; dir = 1'b0; load = 1'b0; load_bin = '0; out_ready = 1'b0;
    mbin[0] = 0; mbin[1] = 0; mvld[0] = 1'b0; mvld[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_gray", int'(g0), 0);
    chk("reset_tc", int'(t0), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Sixteen up steps in wrap mode, one bit change each.
    prev = g0;
    for (int i = 0; i < 16; i++) begin
      step(1, 1, 0, 4'h0, 1);
      chk("one_bit_change", $countones(g0 ^ prev), 1);
      prev = g0;
    end
    chk("wrap_to_zero", int'(g0), 0);
    chk("wrap_tc", int'(t0), 1);

    // Load wins over en.
    step(1, 1, 1, 4'b0101, 1);
    chk("load_gray", int'(g0), 4'b0111);
    chk("load_tc", int'(t0), 0);
    chk("load_valid", int'(v0), 1);
    step(1, 0, 0, 4'h0, 1);
    chk("down_after_load", int'(g0), 4'b0110);

    // Saturating hold at the top, then step down.
    step(0, 0, 1, 4'hf, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 4'h0, 1);
      chk("sat_hold", int'(g1), 4'b1000);
      chk("sat_tc", int'(t1), 1);
    end
    step(1, 0, 0, 4'h0, 1);
    chk("sat_down", int'(g1), 4'b1001);
    chk("sat_down_tc", int'(t1), 0);

    // Wrap down from zero.
    step(0, 0, 1, 4'h0, 1);
    step(1, 0, 0, 4'h0, 1);
    chk("wrap_down", int'(g0), 4'b1000);
    chk("wrap_down_tc", int'(t0), 1);

    // Stall: requests ignored while the code is held.
    step(0, 0, 1, 4'h0, 1);
    step(1, 1, 0, 4'h0, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 4'h0, 0);
      chk("stall_gray", int'(g0), 4'b0001);
      chk("stall_busy", int'(b0), 1);
    end
    step(1, 1, 0, 4'h0, 1);
    chk("after_stall", int'(g0), 4'b0011);

    // Reset mid-count, then first up step.
    do_reset();
    step(1, 1, 0, 4'h0, 1);
    chk("post_reset_step", int'(g0), 4'b0001);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      step(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
           4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end
    step(0, 0, 0, 4'h0, 1);
    step(0, 0, 0, 4'h0, 1);
    @(negedge clk);
    #1;
    chk("queue_drained_wrap", q0.size(), 0);
    chk("queue_drained_sat", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
